// File: rtl/seq_adder_ctrl_if.sv
// Request/result handshake bundle for the byte-serial adder.
// The master side issues operands and consumes the result; the slave side is the adder.
interface seq_adder_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    // Request channel
    logic         in_val;
    logic         in_rdy;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;

    // Result channel
    logic         out_val;
    logic         out_rdy;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    // Status
    logic         busy;

    modport master (
        output in_val, op, a, b, cin, out_rdy,
        input  in_rdy, out_val, result, cout, ovf, busy
    );

    modport slave (
        input  in_val, op, a, b, cin, out_rdy,
        output in_rdy, out_val, result, cout, ovf, busy
    );
endinterface

// File: rtl/seq_adder_ctrl.sv
// Byte-serial adder/subtractor: one 8-bit adder slice processes the operands
// LSB byte first over NBYTES cycles, then holds the result until consumed.
module seq_adder_ctrl #(
    parameter int NBYTES = 4
) (
    input logic            clk,
    input logic            rst_n,
    seq_adder_ctrl_if.slave bus
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    // Operands are held byte-addressable so the active byte is a plain index.
    logic [NBYTES-1:0][7:0] a_q;
    logic [NBYTES-1:0][7:0] b_q;       // effective B (already inverted for subtract)
    logic [NBYTES-1:0][7:0] result_q;
    logic [IW-1:0]          idx_q;
    logic                   carry_q;
    logic                   cout_q;
    logic                   ovf_q;

    logic                   accept;
    logic                   last_byte;
    logic [7:0]             slice_sum;
    logic                   slice_cout;

    assign accept    = (state_q == IDLE) && bus.in_val;
    assign last_byte = (idx_q == IW'(NBYTES - 1));

    // The one and only adder: 8-bit slice fed by the current byte and the carry register.
    always_comb begin
        {slice_cout, slice_sum} = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {8'd0, carry_q};
    end

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values, with no dependence on block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and handshake outputs (Moore: decoded from state only).
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state_q;
        bus.in_rdy  = 1'b0;
        bus.out_val = 1'b0;
        bus.busy    = 1'b1;
        unique case (state_q)
            IDLE: begin
                bus.in_rdy = 1'b1;
                bus.busy   = 1'b0;
                if (bus.in_val) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_byte) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_val = 1'b1;
                if (bus.out_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture at accept, then one byte per cycle through the slice.
    // NOTE: the datapath registers are reset along with the FSM so result,
    // cout and ovf read as zero after reset rather than as stale values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            // Subtract is A + ~B + 1; op overrides cin so the two never combine.
            b_q     <= bus.op ? ~bus.b : bus.b;
            carry_q <= bus.op ? 1'b1 : bus.cin;
            idx_q   <= '0;
        end else if (state_q == CALC) begin
            result_q[idx_q] <= slice_sum;
            carry_q         <= slice_cout;
            if (last_byte) begin
                idx_q  <= '0;
                cout_q <= slice_cout;
                // Signed overflow: like-signed operands giving an opposite-signed result.
                ovf_q  <= (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                          (slice_sum[7] != a_q[NBYTES-1][7]);
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_seq_adder_ctrl.sv
// Directed bench for seq_adder_ctrl (NBYTES = 4) with hand-computed expectations.
module tb_seq_adder_ctrl;
    localparam int NBYTES = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    seq_adder_ctrl_if #(.NBYTES(NBYTES)) bus ();

    seq_adder_ctrl #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, count latency, check result, optional
    // backpressure for `hold` cycles, then complete the handshake.
    task automatic run_op(input string tag, input logic o, input logic [31:0] av,
                          input logic [31:0] bv, input logic ci, input logic [31:0] er,
                          input logic ec, input logic eo, input int hold, input bit scramble);
        int lat;
        @(negedge clk);
        check({tag, "_in_rdy"}, bus.in_rdy, 1'b1);
        bus.in_val = 1'b1;
        bus.op     = o;
        bus.a      = av;
        bus.b      = bv;
        bus.cin    = ci;
        @(posedge clk);
        #1;
        bus.in_val = 1'b0;
        check({tag, "_busy"}, bus.busy, 1'b1);
        lat = 0;
        while (!bus.out_val && lat < 20) begin
            if (scramble) begin
                bus.a      = ~bus.a;
                bus.b      = bus.b + 32'h0101_0101;
                bus.op     = ~bus.op;
                bus.cin    = ~bus.cin;
                bus.in_val = ~bus.in_val;
                bus.out_rdy = ~bus.out_rdy;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_val  = 1'b0;
        bus.out_rdy = 1'b0;
        check({tag, "_latency"}, lat, NBYTES);
        check({tag, "_result"}, bus.result, er);
        check({tag, "_cout"}, bus.cout, ec);
        check({tag, "_ovf"}, bus.ovf, eo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_val"}, bus.out_val, 1'b1);
            check({tag, "_hold_res"}, bus.result, er);
            check({tag, "_hold_rdy"}, bus.in_rdy, 1'b0);
        end
        @(negedge clk);
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.out_rdy = 1'b0;
        check({tag, "_done_val"}, bus.out_val, 1'b0);
        check({tag, "_idle_rdy"}, bus.in_rdy, 1'b1);
        check({tag, "_idle_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.in_val  = 1'b0;
        bus.op      = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.cin     = 1'b0;
        bus.out_rdy = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_val", bus.out_val, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_result", bus.result, 32'h0);
        check("rst_cout", bus.cout, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_rdy", bus.in_rdy, 1'b1);

        // Arithmetic vectors (accept happens on the first rising edge after release).
        run_op("add_wrap",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
        run_op("add_ovf",    1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0);
        run_op("add_cin",    1'b0, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub_borrow", 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub_ovf",    1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
        run_op("sub_cin1",   1'b1, 32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 0, 1'b0);
        run_op("add_negovf", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0, 1'b0);

        // Backpressure: result held for 10 cycles with out_rdy low.
        run_op("backpress",  1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 10, 1'b0);

        // Inputs change every CALC cycle; only the accept-edge values count.
        run_op("scramble",   1'b1, 32'h0000_1000, 32'h0000_0001, 1'b0, 32'h0000_0FFF, 1'b1, 1'b0, 2, 1'b1);

        // Reset in the middle of CALC, after two bytes.
        @(negedge clk);
        bus.in_val = 1'b1;
        bus.op     = 1'b0;
        bus.a      = 32'hAAAA_AAAA;
        bus.b      = 32'h5555_5555;
        bus.cin    = 1'b0;
        @(posedge clk);
        #1;
        bus.in_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_val", bus.out_val, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst",   1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_adder_ctrl.md
SEQ_ADDER_CTRL -- requirements
Module: seq_adder_ctrl

Interface
REQ-001 Parameter: NBYTES, default 4, operand width in bytes (legal 2..8); W = 8*NBYTES.
REQ-002 Port: clk  in  1  sole clock, rising-edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: in_val  in  1  request valid.
REQ-005 Port: in_rdy  out  1  block accepts request.
REQ-006 Port: op  in  1  0 = add (a+b+cin), 1 = subtract (a-b, cin ignored).
REQ-007 Port: a  in  W  operand A.
REQ-008 Port: b  in  W  operand B.
REQ-009 Port: cin  in  1  carry-in for add.
REQ-010 Port: out_val  out  1  result valid.
REQ-011 Port: out_rdy  in  1  consumer accepts result.
REQ-012 Port: result  out  W  sum/difference.
REQ-013 Port: cout  out  1  final carry out (subtract: 1 = no borrow, a >= b unsigned).
REQ-014 Port: ovf  out  1  two's-complement signed overflow.
REQ-015 Port: busy  out  1  high in CALC or DONE.

Function
REQ-016 Single internal 8-bit adder slice (in0, in1, cin -> sum, cout) SHALL be the only adder; computation SHALL be byte-serial, LSB byte first.
REQ-017 FSM states SHALL be IDLE, CALC, DONE; in_rdy = 1 only in IDLE; out_val = 1 only in DONE.
REQ-018 IDLE: in_val=1 accepts; a, b (inverted if op=1), op, carry (cin if op=0, 1 if op=1) registered; byte index cleared; next state CALC.
REQ-019 Inputs a, b, op, cin SHALL be sampled only at the accepting edge; later changes have no effect.
REQ-020 CALC: each cycle adds byte[idx] of A and effective B with carry register; sum byte written to result[8*idx+7:8*idx]; carry register <= slice cout; idx increments.
REQ-021 After the byte with idx = NBYTES-1 is written, next state SHALL be DONE; CALC lasts exactly NBYTES cycles.
REQ-022 Latency: request accepted at edge k SHALL give out_val = 1 after edge k+NBYTES.
REQ-023 DONE: result, cout, ovf held stable while out_val=1 and out_rdy=0, for any duration.
REQ-024 DONE with out_rdy=1: handshake completes, next state IDLE; new request earliest accepted the following cycle (no same-cycle turnaround).
REQ-025 cout SHALL equal carry register after final byte.
REQ-026 ovf SHALL be 1 iff MSB(A) == MSB(effective B) and MSB(result) != MSB(A).
REQ-027 Add with cin=1 and subtract SHALL never occur simultaneously; op=1 overrides cin.
REQ-028 result, cout, ovf values outside DONE SHALL not be relied upon, but SHALL not change except via CALC writes.
REQ-029 out_rdy in IDLE/CALC and in_val in CALC/DONE SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately, asynchronously force state IDLE, in_rdy=1 after release, out_val=0, busy=0, result=0, cout=0, ovf=0, idx=0, carry=0.
REQ-031 Reset asserted mid-CALC or in DONE SHALL discard the operation with no result handshake.
REQ-032 First accept allowed on the first rising edge with rst_n=1.

Verification (NBYTES=4)
REQ-033 add a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 CALC cycles result=0x00000000, cout=1, ovf=0.
REQ-034 add a=0x7FFFFFFF, b=0x00000001, cin=0 -> result=0x80000000, cout=0, ovf=1; add a=0x000000FF, b=0, cin=1 -> result=0x00000100 (carry ripples across byte).
REQ-035 sub a=5, b=7 -> result=0xFFFFFFFE, cout=0, ovf=0; sub a=0x80000000, b=1 -> result=0x7FFFFFFF, cout=1, ovf=1.
REQ-036 Backpressure: out_rdy=0 for 10 cycles in DONE -> out_val and result stable, in_rdy=0; out_rdy=1 -> IDLE next cycle, in_rdy=1.
REQ-037 Reset mid-CALC (after 2 bytes) -> out_val=0, busy=0 at once; new request 3+4 afterwards -> result=0x00000007 with exact 4-cycle latency.
REQ-038 Operand change during CALC (a, b toggled each cycle) -> result matches values sampled at accept edge.
